// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter with an internal baud divider and a transmit FIFO.
// Frames go out back-to-back while the FIFO holds data. Writes into a full
// FIFO are dropped and flagged on overrun.
// Optional feature: define UART_TX_PARITY_EN to insert one parity bit after
// the data bits (even parity, or odd parity when PARITY_ODD=1).
// Ports:
//   clk      system clock
//   rstn     synchronous reset, active low
//   start    write strobe; pushes data when ready=1
//   data     word to enqueue
//   ready    FIFO not full (combinational from count)
//   tx       serial output, registered, idle high
//   busy     frame in progress, registered
//   count    FIFO occupancy
//   overrun  one-cycle pulse: start asserted while ready=0
module uart_tx_fifo #(
  parameter int unsigned DIVISOR    = 104,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     start,
  input  logic [DATA_BITS-1:0]     data,
  output logic                     ready,
  output logic                     tx,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overrun
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned BW = $clog2(DIVISOR);
  localparam int unsigned NW = 4;

  // Elaboration-time parameter sanity checks
  if (DIVISOR < 2) begin : g_bad_divisor
    $error("uart_tx_fifo: DIVISOR must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_fifo: DATA_BITS must be 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo: DEPTH must be a power of 2, >= 2");
  end
  if (PARITY_ODD > 1) begin : g_bad_parity_odd
    $error("uart_tx_fifo: PARITY_ODD must be 0 or 1");
  end

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t                 state_q, state_d;
  logic [BW-1:0]          baud_q, baud_d;
  logic [NW-1:0]          bcnt_q, bcnt_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic                   tx_q, tx_d;
  logic                   busy_q, overrun_q;
  logic [AW-1:0]          wptr_q, rptr_q;
  logic [CW-1:0]          count_q;
  logic [DATA_BITS-1:0]   mem [DEPTH];
  logic                   push, pop, tick;
  logic [DATA_BITS-1:0]   head;
`ifdef UART_TX_PARITY_EN
  logic                   par_q, par_d;
`endif

  assign ready   = (count_q != CW'(DEPTH));
  assign push    = rstn & start & ready;
  assign tick    = (baud_q == BW'(DIVISOR - 1));
  assign head    = mem[rptr_q];
  assign tx      = tx_q;
  assign busy    = busy_q;
  assign count   = count_q;
  assign overrun = overrun_q;

  // Next-state, shifter and serial output logic
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bcnt_d  = bcnt_q;
    shreg_d = shreg_q;
    tx_d    = tx_q;
    pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    if (state_q != IDLE) begin
      baud_d = tick ? '0 : baud_q + BW'(1);
    end
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = START;
          tx_d    = 1'b0;
          baud_d  = '0;
        end
      end
      START: begin
        if (tick) begin
          tx_d    = shreg_q[0];
          bcnt_d  = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          if (bcnt_q == NW'(DATA_BITS - 1)) begin
            bcnt_d  = '0;
`ifdef UART_TX_PARITY_EN
            state_d = PAR;
            tx_d    = par_q;
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bcnt_d  = bcnt_q + NW'(1);
            shreg_d = shreg_q >> 1;
            tx_d    = shreg_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PAR: begin
        if (tick) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      STOP: begin
        if (tick) begin
          if (bcnt_q == NW'(STOP_BITS - 1)) begin
            // Chain straight into the next frame when data is waiting
            if (count_q != '0) begin
              pop     = 1'b1;
              state_d = START;
              tx_d    = 1'b0;
            end else begin
              state_d = IDLE;
              tx_d    = 1'b1;
            end
          end else begin
            bcnt_d = bcnt_q + NW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
    // Load the popped word (and its parity) into the shifter
    if (pop) begin
      shreg_d = head;
      bcnt_d  = '0;
`ifdef UART_TX_PARITY_EN
      par_d   = (^head) ^ 1'(PARITY_ODD);
`endif
    end
  end

  // State, datapath and FIFO bookkeeping registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bcnt_q    <= '0;
      shreg_q   <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
`ifdef UART_TX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bcnt_q    <= bcnt_d;
      shreg_q   <= shreg_d;
      tx_q      <= tx_d;
      busy_q    <= (state_d != IDLE);
      overrun_q <= start & ~ready;
      count_q   <= count_q + CW'(push) - CW'(pop);
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
`ifdef UART_TX_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push) mem[wptr_q] <= data;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed self-checking bench for uart_tx_fifo.
// dut_a: DIVISOR=4, 8 data bits, 1 stop, DEPTH=4, even parity sense.
// dut_b: DIVISOR=4, 5 data bits, 2 stop bits.
// dut_c: as dut_a with PARITY_ODD=1.
module tb_uart_tx_fifo;

  localparam int DIV = 4;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int FA = (1 + 8 + P + 1) * DIV;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
  logic [7:0] data_a = '0, data_c = '0;
  logic [4:0] data_b = '0;
  logic       ready_a, ready_b, ready_c;
  logic       tx_a, tx_b, tx_c;
  logic       busy_a, busy_b, busy_c;
  logic [2:0] count_a, count_b, count_c;
  logic       overrun_a, overrun_b, overrun_c;

  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  uart_tx_fifo #(.DIVISOR(DIV), .DATA_BITS(8), .STOP_BITS(1), .DEPTH(4), .PARITY_ODD(0)) dut_a (
    .clk(clk), .rstn(rstn), .start(start_a), .data(data_a), .ready(ready_a),
    .tx(tx_a), .busy(busy_a), .count(count_a), .overrun(overrun_a));

  uart_tx_fifo #(.DIVISOR(DIV), .DATA_BITS(5), .STOP_BITS(2), .DEPTH(4), .PARITY_ODD(0)) dut_b (
    .clk(clk), .rstn(rstn), .start(start_b), .data(data_b), .ready(ready_b),
    .tx(tx_b), .busy(busy_b), .count(count_b), .overrun(overrun_b));

  uart_tx_fifo #(.DIVISOR(DIV), .DATA_BITS(8), .STOP_BITS(1), .DEPTH(4), .PARITY_ODD(1)) dut_c (
    .clk(clk), .rstn(rstn), .start(start_c), .data(data_c), .ready(ready_c),
    .tx(tx_c), .busy(busy_c), .count(count_c), .overrun(overrun_c));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Expected line level for bit slot idx of a frame carrying word w
  function automatic logic exp_bit(input logic [8:0] w, input int idx, input int nbits, input logic odd);
    if (idx == 0) return 1'b0;
    if (idx <= nbits) return w[idx-1];
    if (P == 1 && idx == nbits + 1) return (^w) ^ odd;
    return 1'b1;
  endfunction

  function automatic logic sel_tx(input int which);
    return (which == 0) ? tx_a : (which == 1) ? tx_b : tx_c;
  endfunction
  function automatic logic sel_busy(input int which);
    return (which == 0) ? busy_a : (which == 1) ? busy_b : busy_c;
  endfunction
  function automatic logic [2:0] sel_count(input int which);
    return (which == 0) ? count_a : (which == 1) ? count_b : count_c;
  endfunction

  task automatic drive(input int which, input logic s, input logic [8:0] w);
    if (which == 0) begin start_a = s; data_a = 8'(w); end
    else if (which == 1) begin start_b = s; data_b = 5'(w); end
    else begin start_c = s; data_c = 8'(w); end
  endtask

  // One write into an idle DUT, then the whole frame checked cycle by cycle
  task automatic run_frame(input int which, input logic [8:0] w, input int nbits,
                           input int nstop, input logic odd);
    int nf;
    nf = (1 + nbits + P + nstop) * DIV;
    @(negedge clk);
    drive(which, 1'b1, w);
    @(negedge clk);
    drive(which, 1'b0, 9'h0);
    check("wr_count", 32'(sel_count(which)), 32'd1);
    check("wr_tx_idle", 32'(sel_tx(which)), 32'd1);
    check("wr_busy", 32'(sel_busy(which)), 32'd0);
    @(negedge clk);
    check("pop_count", 32'(sel_count(which)), 32'd0);
    for (int k = 0; k < nf; k++) begin
      check("frame_tx", 32'(sel_tx(which)), 32'(exp_bit(w, k / DIV, nbits, odd)));
      check("frame_busy", 32'(sel_busy(which)), 32'd1);
      @(negedge clk);
    end
    check("end_tx", 32'(sel_tx(which)), 32'd1);
    check("end_busy", 32'(sel_busy(which)), 32'd0);
  endtask

  logic cap [5*FA];
  int   n;
  logic any_low, any_busy;

  initial begin
    // Reset with start held high: nothing may be pushed
    start_a = 1'b1; data_a = 8'hAA;
    start_b = 1'b1; data_b = 5'h0A;
    start_c = 1'b1; data_c = 8'hAA;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx", 32'(tx_a), 32'd1);
    check("rst_ready", 32'(ready_a), 32'd1);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_count", 32'(count_a), 32'd0);
    check("rst_overrun", 32'(overrun_a), 32'd0);
    check("rst_count_b", 32'(count_b), 32'd0);
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_tx", 32'(tx_a), 32'd1);
    check("idle_count", 32'(count_a), 32'd0);

    // Single frames, including parity-sense variants and the narrow/2-stop DUT
    run_frame(0, 9'h055, 8, 1, 1'b0);
    run_frame(0, 9'h007, 8, 1, 1'b0);
    run_frame(2, 9'h007, 8, 1, 1'b1);
    run_frame(1, 9'h01F, 5, 2, 1'b0);
    run_frame(1, 9'h012, 5, 2, 1'b0);

    // Burst of six writes into DEPTH=4: sixth is rejected with an overrun pulse
    n = 0;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      start_a = 1'b1;
      data_a  = 8'(i + 1);
      @(negedge clk);
      check("burst_count", 32'(count_a), (i == 0) ? 32'd1 : (i < 4) ? 32'(i) : 32'd4);
      check("burst_overrun", 32'(overrun_a), (i == 5) ? 32'd1 : 32'd0);
      check("burst_ready", 32'(ready_a), (i >= 4) ? 32'd0 : 32'd1);
      if (i >= 1) begin
        cap[n] = tx_a;
        n++;
      end
    end
    start_a = 1'b0;
    while (n < 5 * FA) begin
      @(negedge clk);
      if (n == 5) check("burst_overrun_end", 32'(overrun_a), 32'd0);
      cap[n] = tx_a;
      n++;
    end
    for (int k = 0; k < 5 * FA; k++) begin
      check("burst_tx", 32'(cap[k]), 32'(exp_bit(9'((k / FA) + 1), (k % FA) / DIV, 8, 1'b0)));
    end
    @(negedge clk);
    check("burst_end_tx", 32'(tx_a), 32'd1);
    check("burst_end_busy", 32'(busy_a), 32'd0);
    check("burst_end_count", 32'(count_a), 32'd0);

    // Reset during data bit 3 with two words still queued
    repeat (4) @(negedge clk);
    start_a = 1'b1; data_a = 8'hA5;
    @(negedge clk);
    data_a = 8'h3C;
    @(negedge clk);
    data_a = 8'h96;
    @(negedge clk);
    start_a = 1'b0;
    check("mid_count", 32'(count_a), 32'd2);
    repeat (16) @(negedge clk);
    check("mid_bit3", 32'(tx_a), 32'd0);
    check("mid_busy", 32'(busy_a), 32'd1);
    rstn = 1'b0;
    @(negedge clk);
    check("mid_rst_tx", 32'(tx_a), 32'd1);
    check("mid_rst_count", 32'(count_a), 32'd0);
    check("mid_rst_busy", 32'(busy_a), 32'd0);
    check("mid_rst_ready", 32'(ready_a), 32'd1);
    rstn = 1'b1;
    any_low = 1'b0;
    any_busy = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (tx_a == 1'b0) any_low = 1'b1;
      if (busy_a) any_busy = 1'b1;
    end
    check("post_rst_no_frame", 32'(any_low), 32'd0);
    check("post_rst_no_busy", 32'(any_busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised asynchronous serial transmitter with an internal baud divider and a transmit FIFO. It serves as the next-generation UART TX for the peripheral set. Data width, stop-bit count, bit period and FIFO depth are all configurable. Frames are sent back-to-back with no idle gap while the FIFO holds data, and writes into a full FIFO are flagged.

Parameters:
DIVISOR, 104, clk cycles per serial bit (>=2); 104 = 115200 baud at 12 MHz
DATA_BITS, 8, data bits per frame, legal 5..9
STOP_BITS, 1, stop bits per frame, legal 1 or 2
DEPTH, 4, FIFO entries, power of 2, >=2
PARITY_ODD, 0, parity sense when parity is compiled in (0 even, 1 odd)

Ports:
clk  in  1  system clock
rstn  in  1  synchronous reset, active low
start  in  1  write strobe; pushes data when ready=1
data  in  DATA_BITS  byte/word to enqueue
ready  out  1  FIFO not full (count != DEPTH); combinational from count
tx  out  1  serial output, registered, idle high
busy  out  1  frame in progress (state != IDLE), registered
count  out  $clog2(DEPTH)+1  FIFO occupancy
overrun  out  1  one-cycle pulse: start asserted while ready=0

Behaviour:
- Interface: reset rstn, synchronous, active-low; clock clk. All state is updated on posedge clk.
- Reset values: tx=1, busy=0, count=0, overrun=0, ready=1, state IDLE, FIFO pointers 0. A reset mid-frame aborts the frame: tx=1 on the next cycle and the FIFO is flushed.
- FIFO push:
  - start=1 and ready=1 writes data at the write pointer; count increments.
  - start=1 and ready=0 drops the data, leaves count unchanged, and sets overrun=1 for exactly one cycle.
  - A push and a pop in the same cycle leave count unchanged.
  - When count==DEPTH, ready=0 even if a pop happens in that cycle; that write is rejected.
- Pointers are log2(DEPTH) bits wide and wrap naturally.
- FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE: tx=1. If count>0, pop the head into the shift register, clear the bit counter, set tx<=0, baud counter<=0, go to START.
  - Baud counter runs 0..DIVISOR-1. A bit tick fires when it equals DIVISOR-1, then it wraps to 0. Every bit therefore lasts exactly DIVISOR cycles.
  - START: on tick, tx<=data bit 0, go to DATA.
  - DATA: bits are sent LSB first. On tick, shift. After DATA_BITS bits, go to PAR (parity compiled in, tx<=parity) or to STOP (tx<=1).
  - PAR: on tick, go to STOP, tx<=1.
  - STOP: lasts STOP_BITS ticks. On the final tick:
    - count>0: pop and go to START with tx<=0 (no idle cycle between frames).
    - otherwise: go to IDLE with tx=1.
- Frame length = (1+DATA_BITS+P+STOP_BITS)*DIVISOR cycles, where P=1 with parity, else 0.
- Latency: a write into an empty FIFO while IDLE puts tx low 2 cycles after the write edge (the write edge, then the pop edge).
- busy=1 from the pop edge until the return to IDLE.
- A pop at the final stop tick and a push in the same cycle follow the same-cycle count rule above.

Optional Feature:
Macro UART_TX_PARITY_EN.
- Defined: one parity bit is inserted after the data bits. Its value is XOR of the data bits XOR PARITY_ODD, computed from the popped word.
- Undefined: no PAR state and no parity bit; PARITY_ODD is ignored; frame length uses P=0.

Test Plan:
- Reset: hold rstn=0 for 3 cycles with start=1 -> tx=1, ready=1, busy=0, count=0, overrun=0; no push occurs.
- Single frame (DIVISOR=4, DATA_BITS=8, STOP_BITS=1, no parity): write 0x55 -> tx low 2 cycles later. Then 4-cycle bits 1,0,1,0,1,0,1,0, then 4 cycles high. busy high for 40 cycles.
- Burst/overrun (DEPTH=4): start=1 for 6 consecutive cycles with 0x01..0x06.
  - count sequence 1,1,2,3,4; 6th write rejected with overrun pulse.
  - 0x01..0x05 sent as 5 frames in 200 contiguous cycles with no tx high gap beyond the stop bits.
- Parity (macro defined, PARITY_ODD=0): 0x07 -> parity bit 1, frame 44 cycles. With PARITY_ODD=1 -> parity bit 0.
- Reset mid-frame: assert rstn=0 during data bit 3 with 2 words queued -> tx=1 next cycle, count=0, busy=0; no further frames.
- Width/stop (DATA_BITS=5, STOP_BITS=2, DIVISOR=4): write 0x1F -> start, 5 ones, 2 stop bits; frame 32 cycles.
